// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter (asr/lsr/ror/lsl) with valid/ready on both sides.
// Optional BARREL_ROUND_EN adds a bias pre-stage so mode 0 rounds toward zero.
module barrel_shift_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shift,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_lost
);

  typedef enum logic [1:0] {
    MODE_ASR = 2'd0,
    MODE_LSR = 2'd1,
    MODE_ROR = 2'd2,
    MODE_LSL = 2'd3
  } mode_e;

  logic [SHW-1:0]   st_valid;
  logic [SHW-1:0]   st_lost;
  logic [WIDTH-1:0] st_data  [SHW];
  logic [SHW-1:0]   st_shift [SHW];
  mode_e            st_mode  [SHW];

  logic [SHW-1:0]   fd_valid;
  logic [SHW-1:0]   fd_lost;
  logic [WIDTH-1:0] fd_data  [SHW];
  logic [SHW-1:0]   fd_shift [SHW];
  mode_e            fd_mode  [SHW];

  logic [WIDTH-1:0] nx_data  [SHW];
  logic [SHW-1:0]   nx_lost;
  logic [SHW-1:0]   free;

  logic             src_valid;
  logic             src_lost;
  logic [WIDTH-1:0] src_data;
  logic [SHW-1:0]   src_shift;
  mode_e            src_mode;

`ifdef BARREL_ROUND_EN
  // Mode 0 lost bits come from the unbiased operand, so stages must not re-derive them.
  localparam bit ASR_LOST_IN_STAGES = 1'b0;

  logic             pre_valid;
  logic             pre_lost;
  logic [WIDTH-1:0] pre_data;
  logic [SHW-1:0]   pre_shift;
  mode_e            pre_mode;
  logic [WIDTH-1:0] low_mask;
  logic [WIDTH-1:0] bias;

  always_comb begin
    low_mask = ~({WIDTH{1'b1}} << in_shift);
    bias     = '0;
    if (mode_e'(in_mode) == MODE_ASR && in_data[WIDTH-1])
      bias = low_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_valid <= 1'b0;
      pre_lost  <= 1'b0;
      pre_data  <= '0;
      pre_shift <= '0;
      pre_mode  <= MODE_ASR;
    end else if (in_ready) begin
      pre_valid <= in_valid;
      if (in_valid) begin
        pre_data  <= in_data + bias;
        pre_shift <= in_shift;
        pre_mode  <= mode_e'(in_mode);
        pre_lost  <= (mode_e'(in_mode) == MODE_ASR) && (|(in_data & low_mask));
      end
    end
  end

  assign in_ready = !pre_valid || free[0];

  always_comb begin
    src_valid = pre_valid;
    src_lost  = pre_lost;
    src_data  = pre_data;
    src_shift = pre_shift;
    src_mode  = pre_mode;
  end
`else
  localparam bit ASR_LOST_IN_STAGES = 1'b1;

  assign in_ready = free[0];

  always_comb begin
    src_valid = in_valid;
    src_lost  = 1'b0;
    src_data  = in_data;
    src_shift = in_shift;
    src_mode  = mode_e'(in_mode);
  end
`endif

  // A stage may load when it is empty or its content leaves this cycle.
  always_comb begin
    logic f;
    free          = '0;
    f             = !st_valid[SHW-1] || out_ready;
    free[SHW-1]   = f;
    for (int unsigned i = 1; i < SHW; i++) begin
      f               = !st_valid[SHW-1-i] || f;
      free[SHW-1-i]   = f;
    end
  end

  always_comb begin
    fd_valid[0] = src_valid;
    fd_lost[0]  = src_lost;
    fd_data[0]  = src_data;
    fd_shift[0] = src_shift;
    fd_mode[0]  = src_mode;
    for (int unsigned k = 1; k < SHW; k++) begin
      fd_valid[k] = st_valid[k-1];
      fd_lost[k]  = st_lost[k-1];
      fd_data[k]  = st_data[k-1];
      fd_shift[k] = st_shift[k-1];
      fd_mode[k]  = st_mode[k-1];
    end
    for (int unsigned k = 0; k < SHW; k++) begin
      int unsigned amt;
      amt        = 1 << k;
      nx_data[k] = fd_data[k];
      nx_lost[k] = fd_lost[k];
      if (fd_shift[k][k]) begin
        unique case (fd_mode[k])
          MODE_ASR: begin
            nx_data[k] = $signed(fd_data[k]) >>> amt;
            if (ASR_LOST_IN_STAGES)
              nx_lost[k] = fd_lost[k] | (|(fd_data[k] & ~({WIDTH{1'b1}} << amt)));
          end
          MODE_LSR: begin
            nx_data[k] = fd_data[k] >> amt;
            nx_lost[k] = fd_lost[k] | (|(fd_data[k] & ~({WIDTH{1'b1}} << amt)));
          end
          MODE_ROR: begin
            nx_data[k] = (fd_data[k] >> amt) | (fd_data[k] << (WIDTH - amt));
          end
          MODE_LSL: begin
            nx_data[k] = fd_data[k] << amt;
            nx_lost[k] = fd_lost[k] | (|(fd_data[k] & ~({WIDTH{1'b1}} >> amt)));
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid <= '0;
      st_lost  <= '0;
      for (int unsigned k = 0; k < SHW; k++) begin
        st_data[k]  <= '0;
        st_shift[k] <= '0;
        st_mode[k]  <= MODE_ASR;
      end
    end else begin
      for (int unsigned k = 0; k < SHW; k++) begin
        if (free[k]) begin
          st_valid[k] <= fd_valid[k];
          if (fd_valid[k]) begin
            st_data[k]  <= nx_data[k];
            st_lost[k]  <= nx_lost[k];
            st_shift[k] <= fd_shift[k];
            st_mode[k]  <= fd_mode[k];
          end
        end
      end
    end
  end

  assign out_valid = st_valid[SHW-1];
  assign out_data  = st_data[SHW-1];
  assign out_lost  = st_lost[SHW-1];

endmodule

// File: doc/barrel_shift_pipe.md
# barrel_shift_pipe

Parametrised, pipelined barrel shifter/divider with valid/ready flow control on both sides. Each input word is shifted by a run-time amount, with four modes: arithmetic right (signed divide by 2^n), logical right, rotate right, and logical left. The shifter uses one register stage per shift-amount bit, so wide words close timing. It sits in the datapath wherever power-of-two scaling of streamed samples is needed, and supersedes the fixed 8-bit single-mode divider.

## Interface
- WIDTH, 16: data width. Must be a power of two, 4..64.
- SHW, $clog2(WIDTH): derived shift-amount width. Must not be overridden.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  the block accepts the input this cycle.
- in_data  in  WIDTH  operand, two's complement in mode 0.
- in_shift  in  SHW  shift amount n, 0..WIDTH-1.
- in_mode  in  2  0 = arithmetic right, 1 = logical right, 2 = rotate right, 3 = logical left.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result this cycle.
- out_data  out  WIDTH  shifted result.
- out_lost  out  1  sticky flag: at least one 1-bit was discarded.

## Operation
- Transfer rule: a transfer happens when valid and ready are both 1 on a rising edge. This applies to both ports.
- Pipeline: stages k = 0..SHW-1. Stage k shifts by 2^k when in_shift[k] = 1, otherwise it passes the data through.
  - Each stage registers: data, the remaining shift bits, mode, the lost flag, and a valid bit.
- Fill bits:
  - Mode 0 fills with the original MSB.
  - Modes 1 and 3 fill with 0.
  - Mode 2 fills with the bits shifted out.
- out_lost:
  - Modes 0 and 1: OR of all bits shifted off the LSB end.
  - Mode 3: OR of all bits shifted off the MSB end.
  - Mode 2: always 0.
  - The flag is accumulated stage by stage.
- Mode 0 result equals floor(in_data / 2^n), signed.
- n = 0 in any mode gives out_data = in_data and out_lost = 0.
- Stall rule:
  - A stage advances when the next stage is empty or is itself advancing.
  - The last stage advances on out_ready.
  - in_ready = !stage0_valid || stage0_advances (combinational path from out_ready).
  - No bubbles are inserted: a full pipe accepts one word per cycle while out_ready = 1.
- Backpressure: while out_valid = 1 and out_ready = 0, out_data and out_lost hold stable, and upstream stages compact into empty slots.
- Reset: asserting rst_n mid-operation discards all in-flight words immediately. After reset:
  - all stage valid bits, out_valid and out_lost are 0;
  - out_data is 0;
  - in_ready is 1.

## Timing
- Latency: SHW cycles from the input transfer to out_valid = 1 (for example, 4 cycles at WIDTH = 16), or SHW+1 cycles with BARREL_ROUND_EN.
- Throughput: 1 word per cycle when unstalled.
- Capacity: SHW words in flight (SHW+1 with the macro).
- Simultaneous input and output transfers on a full pipe are legal and lose nothing.
- Ordering: results leave in input order.
- No combinational path from in_data, in_shift or in_mode to any output.

## Configuration
- BARREL_ROUND_EN defined:
  - Adds a pre-stage register that, for mode 0 with a negative operand, adds the bias 2^n - 1 before shifting.
  - Mode 0 then rounds toward zero, matching signed "/".
  - out_lost still reports the discarded bits of the unbiased operand.
  - Latency is SHW+1.
- BARREL_ROUND_EN undefined: no pre-stage; mode 0 rounds toward minus infinity (floor); latency is SHW.

## Test plan
All vectors use WIDTH = 8.
- Mode 0, 0xF9 (-7), n = 1:
  - without the macro: out_data = 0xFC, out_lost = 1, out_valid 3 cycles after accept;
  - with the macro: out_data = 0xFD, valid 4 cycles after accept.
- Modes 1 / 2 / 3 on 0x81 with n = 1:
  - mode 1: 0x40, lost = 1;
  - mode 2: 0xC0, lost = 0;
  - mode 3: 0x02, lost = 1.
- Mode 0, 0x80, n = 7 gives 0xFF, lost = 0. Any mode with n = 0 on 0x5A gives 0x5A, lost = 0.
- Stream 10 back-to-back words with out_ready = 1 -> 10 consecutive out_valid cycles, in order, in_ready held at 1.
- Hold out_ready = 0 for 6 cycles while feeding a stream:
  - in_ready drops once SHW words are buffered;
  - out_data stays stable;
  - on release, no word is lost or duplicated.
- Drop rst_n with 2 words in flight -> out_valid = 0 and out_data = 0 immediately, in_ready = 1. Words sent after release are unaffected.
